pipeline_ctrl: RTL and testbench
================================

Name: pipeline_ctrl

Overview:
- Central pipeline-control sequencer for the 5-stage RISC-V core.
- Consumes the stall request from the load-use hazard unit, the taken-branch flush from EX, and the data-memory busy handshake from MEM.
- Drives every pipeline-register write-enable, flush and bubble.
- Sequences multi-cycle flush and memory-wait episodes, keeps saturating performance counters, and flags memory timeouts.

Parameters:
FLUSH_CYCLES, 1, extra cycles IF/ID stays flushed after a taken branch (covers synchronous I-mem latency); range 0..7
MEM_TIMEOUT, 255, MEM_WAIT cycles before mem_timeout_err sets; range 1..2^16-1
CNT_W, 16, width of each performance counter

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
hz_stall  in  2  load-use stall request from the hazard unit; any nonzero value means stall
ex_branch_taken  in  1  branch/jump taken, resolved in EX this cycle
mem_req  in  1  EX/MEM holds a load/store this cycle
mem_busy  in  1  data memory not ready; valid only with mem_req
pc_we  out  1  PC register write enable
if_id_we  out  1  IF/ID write enable
if_id_flush  out  1  IF/ID loads NOP
id_ex_we  out  1  ID/EX write enable
id_ex_bubble  out  1  ID/EX loads NOP (controls zeroed)
ex_mem_we  out  1  EX/MEM write enable
mem_wb_bubble  out  1  MEM/WB loads NOP
mem_timeout_err  out  1  sticky timeout flag
stall_cnt  out  CNT_W  load-use stall cycles, saturating
flush_cnt  out  CNT_W  branch flush events, saturating
wait_cnt  out  CNT_W  memory-wait cycles, saturating

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State=RUN, all counters=0, mem_timeout_err=0, flush down-counter=0.
  - Outputs are forced: all *_we=0, if_id_flush=1, id_ex_bubble=1, mem_wb_bubble=1.
  - On release, normal behaviour starts at the first clk edge.
- Outputs are Mealy: state plus current inputs, zero latency. The response applies in the same cycle the condition is seen.
- States: RUN, FLUSH, MEM_WAIT. A ret_state register (RUN/FLUSH) records where to resume after MEM_WAIT.
- Priority, highest first:
  1. mem_req&&mem_busy
  2. ex_branch_taken
  3. hz_stall!=0
- Default run outputs: all *_we=1, flush/bubbles=0.
- Memory freeze (any state):
  - Outputs: pc_we=if_id_we=id_ex_we=ex_mem_we=0, mem_wb_bubble=1. Branch and stall inputs are ignored.
  - Next state=MEM_WAIT; ret_state captures the current state, or is kept if already in MEM_WAIT.
  - wait_cnt increments each frozen cycle.
- MEM_WAIT:
  - Timeout counter increments each frozen cycle. When it reaches MEM_TIMEOUT, mem_timeout_err=1 (sticky until reset). The freeze continues.
  - The first cycle with mem_busy=0 evaluates as ret_state, with that state's outputs and transitions. The timeout counter clears on exit.
  - The FLUSH down-counter is paused throughout MEM_WAIT.
- Branch taken (RUN or FLUSH, no freeze):
  - Outputs: pc_we=1, if_id_flush=1, id_ex_bubble=1, others default. flush_cnt increments.
  - If FLUSH_CYCLES=0, stay in or go to RUN. Otherwise go to FLUSH with the down-counter=FLUSH_CYCLES; a new branch taken inside FLUSH reloads the counter.
- FLUSH (no freeze, no new branch):
  - Outputs: pc_we=1, if_id_flush=1, id_ex_bubble=0. hz_stall is masked.
  - Down-counter decrements; go to RUN in the cycle it reaches 0.
- Load-use stall (RUN only, no higher event):
  - Outputs: pc_we=0, if_id_we=0, id_ex_bubble=1, others default. stall_cnt increments.
  - State stays RUN. Consecutive stall cycles are each honoured and counted.
- Counters saturate at 2^CNT_W-1 and never wrap.
- Unused hz_stall encodings (2, 3) are treated as 1.

Decomposition:
- pipe_ctrl_pkg holds:
  - state enum (RUN=2'd0, FLUSH=2'd1, MEM_WAIT=2'd2)
  - the ctrl-vector struct (pc_we … mem_wb_bubble) with RUN_CTRL, RESET_CTRL, FREEZE_CTRL, FLUSH_CTRL and STALL_CTRL constants
- One sub-module, sat_counter (parameter W; ports clk, rst_n, inc, count), instantiated three times.

Test Plan:
- Reset mid-MEM_WAIT (mem_busy=1 for 3 cycles, then rst_n=0) -> same-cycle RESET_CTRL; state=RUN, wait_cnt=0, err=0 after release.
- hz_stall=1 for one cycle in RUN -> that cycle pc_we=0, if_id_we=0, id_ex_bubble=1; next cycle RUN_CTRL; stall_cnt=1.
- ex_branch_taken=1 with hz_stall=1, FLUSH_CYCLES=1 -> cycle0: pc_we=1, if_id_flush=1, id_ex_bubble=1, stall_cnt unchanged; cycle1: FLUSH, if_id_flush=1; cycle2: RUN; flush_cnt=1.
- In FLUSH, mem_req=mem_busy=1 for 4 cycles -> 4 freeze cycles, wait_cnt=4; the 5th cycle resumes FLUSH with if_id_flush=1, then RUN.
- MEM_TIMEOUT=3, mem_busy held 5 cycles -> err=1 after the 3rd frozen cycle and stays 1 after mem_busy drops, until rst_n=0.
- CNT_W=4, hz_stall held 20 cycles -> stall_cnt stops at 15.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and control-vector constants for the pipeline-control sequencer.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_t;

    // One bit per pipeline-register control, in pipeline order.
    typedef struct packed {
        logic pc_we;
        logic if_id_we;
        logic if_id_flush;
        logic id_ex_we;
        logic id_ex_bubble;
        logic ex_mem_we;
        logic mem_wb_bubble;
    } ctrl_t;

    // Normal advance: everything writes, nothing is squashed.
    localparam ctrl_t RUN_CTRL = '{pc_we: 1'b1, if_id_we: 1'b1, if_id_flush: 1'b0,
                                   id_ex_we: 1'b1, id_ex_bubble: 1'b0, ex_mem_we: 1'b1,
                                   mem_wb_bubble: 1'b0};

    // Held in reset: nothing writes, every squash asserted.
    localparam ctrl_t RESET_CTRL = '{pc_we: 1'b0, if_id_we: 1'b0, if_id_flush: 1'b1,
                                     id_ex_we: 1'b0, id_ex_bubble: 1'b1, ex_mem_we: 1'b0,
                                     mem_wb_bubble: 1'b1};

    // Data memory busy: the front four registers hold, WB receives a NOP.
    localparam ctrl_t FREEZE_CTRL = '{pc_we: 1'b0, if_id_we: 1'b0, if_id_flush: 1'b0,
                                      id_ex_we: 1'b0, id_ex_bubble: 1'b0, ex_mem_we: 1'b0,
                                      mem_wb_bubble: 1'b1};

    // Post-branch cycles: fetch keeps running, IF/ID stays squashed.
    localparam ctrl_t FLUSH_CTRL = '{pc_we: 1'b1, if_id_we: 1'b1, if_id_flush: 1'b1,
                                     id_ex_we: 1'b1, id_ex_bubble: 1'b0, ex_mem_we: 1'b1,
                                     mem_wb_bubble: 1'b0};

    // Branch resolved taken in EX: squash the two younger instructions.
    localparam ctrl_t BRANCH_CTRL = '{pc_we: 1'b1, if_id_we: 1'b1, if_id_flush: 1'b1,
                                      id_ex_we: 1'b1, id_ex_bubble: 1'b1, ex_mem_we: 1'b1,
                                      mem_wb_bubble: 1'b0};

    // Load-use stall: hold PC and IF/ID, inject a bubble into ID/EX.
    localparam ctrl_t STALL_CTRL = '{pc_we: 1'b0, if_id_we: 1'b0, if_id_flush: 1'b0,
                                     id_ex_we: 1'b1, id_ex_bubble: 1'b1, ex_mem_we: 1'b1,
                                     mem_wb_bubble: 1'b0};

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter used for the pipeline performance counters.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count up on inc, sticking at the all-ones value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= {W{1'b0}};
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central pipeline-control sequencer: stalls, branch flushes and memory freezes.
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int MEM_TIMEOUT  = 255,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       hz_stall,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_busy,
    output logic             pc_we,
    output logic             if_id_we,
    output logic             if_id_flush,
    output logic             id_ex_we,
    output logic             id_ex_bubble,
    output logic             ex_mem_we,
    output logic             mem_wb_bubble,
    output logic             mem_timeout_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] wait_cnt
);

    localparam logic [2:0]  FLUSH_LOAD = 3'(FLUSH_CYCLES);
    localparam logic [15:0] TMO_LAST   = 16'(MEM_TIMEOUT - 1);

    state_t      state_r, state_nxt_s;
    state_t      ret_r, ret_nxt_s;
    state_t      eff_s;
    logic [2:0]  fcnt_r, fcnt_nxt_s;
    logic [15:0] tmo_r, tmo_nxt_s;
    logic        err_r, err_nxt_s;
    logic        freeze_s;
    logic        stall_inc_s, flush_inc_s, wait_inc_s;
    ctrl_t       ctrl_s, ctrl_out_s;

    // Decide this cycle's controls and the next sequencer state from state + inputs.
    always_comb begin
        state_nxt_s = state_r;
        ret_nxt_s   = ret_r;
        fcnt_nxt_s  = fcnt_r;
        tmo_nxt_s   = 16'd0;
        err_nxt_s   = err_r;
        ctrl_s      = RUN_CTRL;
        stall_inc_s = 1'b0;
        flush_inc_s = 1'b0;
        wait_inc_s  = 1'b0;
        freeze_s    = mem_req && mem_busy;
        // Leaving MEM_WAIT behaves exactly like the state it interrupted.
        eff_s       = (state_r == ST_MEM_WAIT) ? ret_r : state_r;

        if (freeze_s) begin
            ctrl_s      = FREEZE_CTRL;
            state_nxt_s = ST_MEM_WAIT;
            ret_nxt_s   = eff_s;
            wait_inc_s  = 1'b1;
            tmo_nxt_s   = (tmo_r == 16'hFFFF) ? tmo_r : tmo_r + 16'd1;
            if (tmo_r >= TMO_LAST) begin
                err_nxt_s = 1'b1;
            end else begin
                err_nxt_s = err_r;
            end
        end else if (ex_branch_taken) begin
            ctrl_s      = BRANCH_CTRL;
            flush_inc_s = 1'b1;
            fcnt_nxt_s  = FLUSH_LOAD;
            if (FLUSH_CYCLES == 0) begin
                state_nxt_s = ST_RUN;
            end else begin
                state_nxt_s = ST_FLUSH;
            end
        end else if (eff_s == ST_FLUSH) begin
            // Stall requests are masked here: IF/ID carries no valid instruction.
            ctrl_s = FLUSH_CTRL;
            if (fcnt_r <= 3'd1) begin
                fcnt_nxt_s  = 3'd0;
                state_nxt_s = ST_RUN;
            end else begin
                fcnt_nxt_s  = fcnt_r - 3'd1;
                state_nxt_s = ST_FLUSH;
            end
        end else if (hz_stall != 2'd0) begin
            ctrl_s      = STALL_CTRL;
            stall_inc_s = 1'b1;
            state_nxt_s = ST_RUN;
        end else begin
            state_nxt_s = ST_RUN;
        end
    end

    // Reset forces the safe control vector immediately, independent of the clock.
    always_comb begin
        if (!rst_n) begin
            ctrl_out_s = RESET_CTRL;
        end else begin
            ctrl_out_s = ctrl_s;
        end
    end

    // Sequencer state, flush down-counter, timeout counter and sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_RUN;
            ret_r   <= ST_RUN;
            fcnt_r  <= 3'd0;
            tmo_r   <= 16'd0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            ret_r   <= ret_nxt_s;
            fcnt_r  <= fcnt_nxt_s;
            tmo_r   <= tmo_nxt_s;
            err_r   <= err_nxt_s;
        end
    end

    assign pc_we           = ctrl_out_s.pc_we;
    assign if_id_we        = ctrl_out_s.if_id_we;
    assign if_id_flush     = ctrl_out_s.if_id_flush;
    assign id_ex_we        = ctrl_out_s.id_ex_we;
    assign id_ex_bubble    = ctrl_out_s.id_ex_bubble;
    assign ex_mem_we       = ctrl_out_s.ex_mem_we;
    assign mem_wb_bubble   = ctrl_out_s.mem_wb_bubble;
    assign mem_timeout_err = err_r;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_inc_s),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (flush_inc_s),
        .count (flush_cnt)
    );

    sat_counter #(.W(CNT_W)) u_wait_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (wait_inc_s),
        .count (wait_cnt)
    );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed table, corner sequences, random vs model.
module tb_pipeline_ctrl;

    localparam int FC  = 1;
    localparam int MT  = 3;
    localparam int CW  = 4;
    localparam int SAT = (1 << CW) - 1;

    // Control vector order: pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_bubble, ex_mem_we, mem_wb_bubble
    localparam logic [6:0] C_RUN    = 7'b1101010;
    localparam logic [6:0] C_RESET  = 7'b0010101;
    localparam logic [6:0] C_FREEZE = 7'b0000001;
    localparam logic [6:0] C_FLUSH  = 7'b1111010;
    localparam logic [6:0] C_BRANCH = 7'b1111110;
    localparam logic [6:0] C_STALL  = 7'b0001110;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    hz_stall;
    logic          ex_branch_taken, mem_req, mem_busy;
    logic          pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_bubble, ex_mem_we, mem_wb_bubble;
    logic          mem_timeout_err;
    logic [CW-1:0] stall_cnt, flush_cnt, wait_cnt;
    logic [6:0]    dut_ctrl;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: pipeline "mode" 0=run, 1=flushing, 2=waiting on memory
    int m_mode, m_resume, m_left, m_frozen, m_stall, m_flush, m_wait;
    bit m_err;

    typedef struct {
        logic [1:0] hz;
        logic       br;
        logic       rq;
        logic       bs;
        logic [6:0] ctrl;
        logic       err;
    } vec_t;
    vec_t tab[$];

    pipeline_ctrl #(.FLUSH_CYCLES(FC), .MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .hz_stall        (hz_stall),
        .ex_branch_taken (ex_branch_taken),
        .mem_req         (mem_req),
        .mem_busy        (mem_busy),
        .pc_we           (pc_we),
        .if_id_we        (if_id_we),
        .if_id_flush     (if_id_flush),
        .id_ex_we        (id_ex_we),
        .id_ex_bubble    (id_ex_bubble),
        .ex_mem_we       (ex_mem_we),
        .mem_wb_bubble   (mem_wb_bubble),
        .mem_timeout_err (mem_timeout_err),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt),
        .wait_cnt        (wait_cnt)
    );

    assign dut_ctrl = {pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_bubble, ex_mem_we, mem_wb_bubble};

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int x);
        return (x > SAT) ? SAT : x;
    endfunction

    function automatic logic [6:0] mdl_ctrl(input logic [1:0] hz, input logic br, input logic rq, input logic bs);
        int ph;
        ph = (m_mode == 2) ? m_resume : m_mode;
        if (rq && bs)      return C_FREEZE;
        else if (br)       return C_BRANCH;
        else if (ph == 1)  return C_FLUSH;
        else if (hz != 0)  return C_STALL;
        else               return C_RUN;
    endfunction

    task automatic mdl_step(input logic [1:0] hz, input logic br, input logic rq, input logic bs);
        int ph;
        ph = (m_mode == 2) ? m_resume : m_mode;
        if (rq && bs) begin
            m_frozen++;
            if (m_frozen >= MT) m_err = 1'b1;
            m_wait   = sat(m_wait + 1);
            m_resume = ph;
            m_mode   = 2;
        end else begin
            m_frozen = 0;
            if (br) begin
                m_flush = sat(m_flush + 1);
                m_left  = FC;
                m_mode  = (FC == 0) ? 0 : 1;
            end else if (ph == 1) begin
                m_left = m_left - 1;
                m_mode = (m_left <= 0) ? 0 : 1;
            end else begin
                if (hz != 2'd0) m_stall = sat(m_stall + 1);
                m_mode = 0;
            end
        end
    endtask

    task automatic mdl_reset();
        m_mode = 0; m_resume = 0; m_left = 0; m_frozen = 0;
        m_stall = 0; m_flush = 0; m_wait = 0; m_err = 1'b0;
    endtask

    // One clock cycle: drive at negedge, check Mealy controls mid-cycle, registers after the edge.
    task automatic cycle(input logic [1:0] hz, input logic br, input logic rq, input logic bs,
                         input bit use_tab, input logic [6:0] tab_ctrl, input logic tab_err);
        @(negedge clk);
        hz_stall = hz; ex_branch_taken = br; mem_req = rq; mem_busy = bs;
        #2;
        check("ctrl_vs_model", 32'(dut_ctrl), 32'(mdl_ctrl(hz, br, rq, bs)));
        if (use_tab) check("ctrl_vs_table", 32'(dut_ctrl), 32'(tab_ctrl));
        @(posedge clk);
        mdl_step(hz, br, rq, bs);
        #1;
        check("timeout_err", 32'(mem_timeout_err), 32'(m_err));
        if (use_tab) check("timeout_err_table", 32'(mem_timeout_err), 32'(tab_err));
        check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
        check("flush_cnt", 32'(flush_cnt), 32'(m_flush));
        check("wait_cnt",  32'(wait_cnt),  32'(m_wait));
    endtask

    // Assert reset mid-cycle (inputs left as they are), verify forced controls, release.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        check("reset_ctrl", 32'(dut_ctrl), 32'(C_RESET));
        check("reset_err", 32'(mem_timeout_err), 32'd0);
        check("reset_cnts", 32'({stall_cnt, flush_cnt, wait_cnt}), 32'd0);
        mdl_reset();
        @(negedge clk);
        hz_stall = 2'd0; ex_branch_taken = 1'b0; mem_req = 1'b0; mem_busy = 1'b0;
        rst_n = 1'b1;
    endtask

    function automatic vec_t mk(input logic [1:0] hz, input logic br, input logic rq, input logic bs,
                                input logic [6:0] c, input logic e);
        vec_t v;
        v.hz = hz; v.br = br; v.rq = rq; v.bs = bs; v.ctrl = c; v.err = e;
        return v;
    endfunction

    initial begin
        logic [1:0] r_hz;
        logic       r_br, r_rq, r_bs;

        rst_n = 1'b0;
        hz_stall = 2'd0; ex_branch_taken = 1'b0; mem_req = 1'b0; mem_busy = 1'b0;
        mdl_reset();
        #1;
        check("por_ctrl", 32'(dut_ctrl), 32'(C_RESET));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table: stall, branch+stall, flush, reload, freeze-in-flush with timeout, resumes
        tab.push_back(mk(2'd0, 1'b0, 1'b0, 1'b0, C_RUN,    1'b0));
        tab.push_back(mk(2'd1, 1'b0, 1'b0, 1'b0, C_STALL,  1'b0));
        tab.push_back(mk(2'd0, 1'b0, 1'b0, 1'b0, C_RUN,    1'b0));
        tab.push_back(mk(2'd1, 1'b1, 1'b0, 1'b0, C_BRANCH, 1'b0));
        tab.push_back(mk(2'd0, 1'b0, 1'b0, 1'b0, C_FLUSH,  1'b0));
        tab.push_back(mk(2'd0, 1'b0, 1'b0, 1'b0, C_RUN,    1'b0));
        tab.push_back(mk(2'd0, 1'b1, 1'b0, 1'b0, C_BRANCH, 1'b0));
        tab.push_back(mk(2'd0, 1'b0, 1'b1, 1'b1, C_FREEZE, 1'b0));
        tab.push_back(mk(2'd0, 1'b1, 1'b1, 1'b1, C_FREEZE, 1'b0));
        tab.push_back(mk(2'd1, 1'b0, 1'b1, 1'b1, C_FREEZE, 1'b1));
        tab.push_back(mk(2'd0, 1'b0, 1'b1, 1'b1, C_FREEZE, 1'b1));
        tab.push_back(mk(2'd0, 1'b0, 1'b1, 1'b0, C_FLUSH,  1'b1));
        tab.push_back(mk(2'd0, 1'b0, 1'b0, 1'b0, C_RUN,    1'b1));
        tab.push_back(mk(2'd0, 1'b0, 1'b1, 1'b0, C_RUN,    1'b1));
        tab.push_back(mk(2'd0, 1'b0, 1'b0, 1'b1, C_RUN,    1'b1));
        tab.push_back(mk(2'd2, 1'b0, 1'b0, 1'b0, C_STALL,  1'b1));
        tab.push_back(mk(2'd3, 1'b0, 1'b0, 1'b0, C_STALL,  1'b1));
        tab.push_back(mk(2'd0, 1'b1, 1'b0, 1'b0, C_BRANCH, 1'b1));
        tab.push_back(mk(2'd1, 1'b0, 1'b0, 1'b0, C_FLUSH,  1'b1));
        tab.push_back(mk(2'd0, 1'b1, 1'b0, 1'b0, C_BRANCH, 1'b1));
        tab.push_back(mk(2'd0, 1'b1, 1'b0, 1'b0, C_BRANCH, 1'b1));
        tab.push_back(mk(2'd0, 1'b0, 1'b0, 1'b0, C_FLUSH,  1'b1));
        tab.push_back(mk(2'd0, 1'b0, 1'b1, 1'b1, C_FREEZE, 1'b1));
        tab.push_back(mk(2'd1, 1'b0, 1'b1, 1'b0, C_STALL,  1'b1));
        tab.push_back(mk(2'd0, 1'b0, 1'b0, 1'b0, C_RUN,    1'b1));
        foreach (tab[i]) begin
            cycle(tab[i].hz, tab[i].br, tab[i].rq, tab[i].bs, 1'b1, tab[i].ctrl, tab[i].err);
        end

        // Reset while frozen with a pending flush: must come back in plain RUN with cleared state
        cycle(2'd0, 1'b1, 1'b0, 1'b0, 1'b1, C_BRANCH, 1'b1);
        for (int i = 0; i < 3; i++) cycle(2'd0, 1'b0, 1'b1, 1'b1, 1'b1, C_FREEZE, 1'b1);
        do_reset();
        cycle(2'd0, 1'b0, 1'b0, 1'b0, 1'b1, C_RUN, 1'b0);
        check("post_reset_wait_cnt", 32'(wait_cnt), 32'd0);

        // Stall held long enough to saturate the narrow counter
        for (int i = 0; i < 20; i++) cycle(2'd1, 1'b0, 1'b0, 1'b0, 1'b1, C_STALL, 1'b0);
        check("stall_cnt_saturated", 32'(stall_cnt), 32'd15);

        // Randomized traffic against the reference model, with occasional resets
        do_reset();
        r_bs = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            r_hz = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            r_br = ($urandom_range(0, 5) == 0);
            r_rq = ($urandom_range(0, 1) == 1);
            r_bs = r_bs ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            cycle(r_hz, r_br, r_rq, r_bs | ($urandom_range(0, 15) == 0), 1'b0, 7'd0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
